adc_scan_sequencer: RTL



---
 rtl/adc_scan_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/adc_scan_sequencer.sv
// Sweeps the five BMS analog channels through one muxed 12-bit ADC and publishes a coherent sample set.
// Sweeps containing a conversion timeout raise a sticky fault and are never published.
module adc_scan_sequencer #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SCAN_PERIOD    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fault_clr,
    input  logic        adc_done,
    input  logic [11:0] adc_data,
    output logic        adc_start,
    output logic [2:0]  adc_ch_sel,
    output logic [11:0] cell_1_voltage_adc,
    output logic [11:0] cell_2_voltage_adc,
    output logic [11:0] cell_3_voltage_adc,
    output logic [11:0] pack_current_adc,
    output logic [11:0] temperature_adc,
    output logic        sample_valid,
    output logic        scan_busy,
    output logic        timeout_fault
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  WAIT_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] PERIOD_LOAD = 16'(SCAN_PERIOD - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       ch_q, ch_d;
    logic [7:0]       settle_cnt_q, settle_cnt_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [15:0]      period_cnt_q, period_cnt_d;
    logic             sweep_bad_q, sweep_bad_d;
    logic [4:0][11:0] shadow_q, shadow_d;
    logic             timeout_set;
    logic             publish;

    logic             adc_start_q;
    logic [4:0][11:0] data_out_q;
    logic             sample_valid_q;
    logic             scan_busy_q;
    logic             timeout_fault_q;

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        settle_cnt_d = settle_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        period_cnt_d = (period_cnt_q != 16'd0) ? period_cnt_q - 16'd1 : 16'd0;
        sweep_bad_d  = sweep_bad_q;
        shadow_d     = shadow_q;
        timeout_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && period_cnt_q == 16'd0) begin
                    state_d      = ST_SETTLE;
                    ch_d         = 3'd0;
                    settle_cnt_d = 8'd0;
                    period_cnt_d = PERIOD_LOAD;
                    sweep_bad_d  = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_START;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            ST_START: begin
                wait_cnt_d = 8'd0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A done in the final WAIT cycle still counts as a good conversion.
                if (adc_done || wait_cnt_q == WAIT_LAST) begin
                    if (adc_done) begin
                        for (int i = 0; i < 5; i++) begin
                            if (ch_q == 3'(i)) shadow_d[i] = adc_data;
                        end
                    end else begin
                        timeout_set = 1'b1;
                        sweep_bad_d = 1'b1;
                    end
                    if (ch_q == 3'd4) begin
                        state_d = ST_DONE;
                    end else begin
                        ch_d         = ch_q + 3'd1;
                        settle_cnt_d = 8'd0;
                        state_d      = ST_SETTLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ch_d    = 3'd0;
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = 3'd0;
            end
        endcase
    end

    // Outputs are registered from next-state so they land in the DONE cycle itself.
    assign publish = (state_d == ST_DONE) && !sweep_bad_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            ch_q            <= 3'd0;
            settle_cnt_q    <= 8'd0;
            wait_cnt_q      <= 8'd0;
            period_cnt_q    <= 16'd0;
            sweep_bad_q     <= 1'b0;
            shadow_q        <= '0;
            adc_start_q     <= 1'b0;
            data_out_q      <= '0;
            sample_valid_q  <= 1'b0;
            scan_busy_q     <= 1'b0;
            timeout_fault_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ch_q            <= ch_d;
            settle_cnt_q    <= settle_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            period_cnt_q    <= period_cnt_d;
            sweep_bad_q     <= sweep_bad_d;
            shadow_q        <= shadow_d;
            adc_start_q     <= (state_d == ST_START);
            sample_valid_q  <= publish;
            scan_busy_q     <= (state_d != ST_IDLE);
            timeout_fault_q <= timeout_set | (timeout_fault_q & ~fault_clr);
            if (publish) begin
                data_out_q <= shadow_d;
            end
        end
    end

    assign adc_start          = adc_start_q;
    assign adc_ch_sel         = ch_q;
    assign cell_1_voltage_adc = data_out_q[0];
    assign cell_2_voltage_adc = data_out_q[1];
    assign cell_3_voltage_adc = data_out_q[2];
    assign pack_current_adc   = data_out_q[3];
    assign temperature_adc    = data_out_q[4];
    assign sample_valid       = sample_valid_q;
    assign scan_busy          = scan_busy_q;
    assign timeout_fault      = timeout_fault_q;

endmodule
